// File: rtl/alu_share_arb.sv
// Shared RV64 integer ALU with two round-robin requesters and a single-entry
// result buffer that drains through a tagged valid/ready response port.
package decode_pkg;
    typedef logic [4:0] alufunc_t;
    localparam alufunc_t ALU_ADD   = 5'd0;
    localparam alufunc_t ALU_SUB   = 5'd1;
    localparam alufunc_t ALU_ADDW  = 5'd2;
    localparam alufunc_t ALU_SUBW  = 5'd3;
    localparam alufunc_t ALU_SLL   = 5'd4;
    localparam alufunc_t ALU_SRL   = 5'd5;
    localparam alufunc_t ALU_SRA   = 5'd6;
    localparam alufunc_t ALU_SLLW  = 5'd7;
    localparam alufunc_t ALU_SRLW  = 5'd8;
    localparam alufunc_t ALU_SRAW  = 5'd9;
    localparam alufunc_t ALU_OR    = 5'd10;
    localparam alufunc_t ALU_XOR   = 5'd11;
    localparam alufunc_t ALU_AND   = 5'd12;
    localparam alufunc_t ALU_SLT   = 5'd13;
    localparam alufunc_t ALU_SLTU  = 5'd14;
    localparam alufunc_t ALU_PASSB = 5'd15;
endpackage

module alu_share_arb
    import decode_pkg::*;
#(
    parameter logic RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  alufunc_t    req0_func,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    input  alufunc_t    req1_func,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [63:0] resp_c
);
    typedef enum logic {EMPTY, FULL} buf_state_t;

    buf_state_t  state_q, state_d;
    logic        prio_q, prio_d;
    logic        id_q, id_d;
    logic [63:0] c_q, c_d;
    logic        can_accept, grant0, grant1, xfer0, xfer1, sel1;
    logic [63:0] op_a, op_b, alu_c;
    alufunc_t    op_func;

    function automatic logic [63:0] alu(input alufunc_t f, input logic [63:0] a,
                                        input logic [63:0] b);
        logic [31:0] w;
        logic [63:0] r;
        w = '0;
        r = '0;
        case (f)
            ALU_ADD:   r = a + b;
            ALU_SUB:   r = a - b;
            ALU_ADDW:  begin w = a[31:0] + b[31:0]; r = {{32{w[31]}}, w}; end
            ALU_SUBW:  begin w = a[31:0] - b[31:0]; r = {{32{w[31]}}, w}; end
            ALU_SLL:   r = a << b[5:0];
            ALU_SRL:   r = a >> b[5:0];
            ALU_SRA:   r = $unsigned($signed(a) >>> b[5:0]);
            ALU_SLLW:  begin w = a[31:0] << b[4:0]; r = {{32{w[31]}}, w}; end
            ALU_SRLW:  begin w = a[31:0] >> b[4:0]; r = {{32{w[31]}}, w}; end
            ALU_SRAW:  begin
                w = $unsigned($signed(a[31:0]) >>> b[4:0]);
                r = {{32{w[31]}}, w};
            end
            ALU_OR:    r = a | b;
            ALU_XOR:   r = a ^ b;
            ALU_AND:   r = a & b;
            ALU_SLT:   r = {63'd0, $signed(a) < $signed(b)};
            ALU_SLTU:  r = {63'd0, a < b};
            ALU_PASSB: r = b;
            default:   r = '0;
        endcase
        return r;
    endfunction

    // Each port's grant looks only at the other port's valid, so a ready may be
    // raised on both ports when neither is valid; at most one can transfer.
    assign can_accept = (state_q == EMPTY) | resp_ready;
    assign grant0     = !req1_valid | !prio_q;
    assign grant1     = !req0_valid | prio_q;
    assign req0_ready = can_accept & grant0;
    assign req1_ready = can_accept & grant1;
    assign xfer0      = req0_valid & req0_ready;
    assign xfer1      = req1_valid & req1_ready;

    // Operand select comes from arbitration only, keeping resp_ready off the ALU path.
    assign sel1    = req1_valid & (prio_q | !req0_valid);
    assign op_a    = sel1 ? req1_a    : req0_a;
    assign op_b    = sel1 ? req1_b    : req0_b;
    assign op_func = sel1 ? req1_func : req0_func;
    assign alu_c   = alu(op_func, op_a, op_b);

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        id_d    = id_q;
        c_d     = c_q;
        if (xfer0 | xfer1) begin
            state_d = FULL;
            c_d     = alu_c;
            id_d    = xfer1;
            prio_d  = !xfer1;
        end else if (resp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= EMPTY;
            prio_q  <= RR_INIT;
            id_q    <= 1'b0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            c_q     <= c_d;
        end
    end

    assign resp_valid = (state_q == FULL);
    assign resp_id    = id_q;
    assign resp_c     = c_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed scoreboard bench for alu_share_arb: stimulus pushes expected
// responses, a negedge monitor pops and compares each delivered result.
module tb_alu_share_arb;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    alufunc_t    req0_func = ALU_ADD, req1_func = ALU_ADD;
    logic        resp_valid, resp_ready = 1'b1, resp_id;
    logic [63:0] resp_c;

    typedef struct packed {
        logic        id;
        logic [63:0] c;
    } resp_t;

    resp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    alu_share_arb #(.RR_INIT(1'b0)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_func  (req0_func),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_func  (req1_func),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_c     (resp_c)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        resp_t r;
        if (resetn === 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got id=%0d c=0x%h expected none", resp_id, resp_c);
            end else begin
                r = exp_q.pop_front();
                check("resp_id", {63'd0, resp_id}, {63'd0, r.id});
                check("resp_c", resp_c, r.c);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic port, input logic [63:0] a, input logic [63:0] b,
                         input alufunc_t f);
        if (port) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_func = f;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_func = f;
        end
    endtask

    // Single-port request on an accepting buffer: must be taken in the first cycle.
    task automatic issue(input logic port, input logic [63:0] a, input logic [63:0] b,
                         input alufunc_t f, input logic [63:0] exp);
        logic rdy;
        drive(port, a, b, f);
        @(negedge clk);
        rdy = port ? req1_ready : req0_ready;
        check(port ? "req1_ready" : "req0_ready", {63'd0, rdy}, 64'd1);
        if (rdy === 1'b1) exp_q.push_back('{id: port, c: exp});
        tick();
        if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0, cnt1, n0, n1;

        resetn = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #12;
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_resp_c", resp_c, 64'd0);
        check("rst_resp_id", {63'd0, resp_id}, 64'd0);
        check("rst_ready0", {63'd0, req0_ready}, 64'd1);
        check("rst_ready1", {63'd0, req1_ready}, 64'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        tick();

        issue(1'b0, 64'd5, 64'd7, ALU_ADD, 64'd12);
        @(negedge clk);
        check("add_resp_valid", {63'd0, resp_valid}, 64'd1);
        tick();
        @(negedge clk);
        check("drain_empty", {63'd0, resp_valid}, 64'd0);
        tick();

        issue(1'b1, 64'h7FFFFFFF, 64'd1, ALU_ADDW, 64'hFFFFFFFF80000000);
        issue(1'b1, 64'd0, 64'd1, ALU_SUBW, 64'hFFFFFFFFFFFFFFFF);
        issue(1'b1, 64'h80000000, 64'd4, ALU_SRAW, 64'hFFFFFFFFF8000000);
        issue(1'b1, 64'hFFFFFFFF80000000, 64'h24, ALU_SRLW, 64'h0000000008000000);
        issue(1'b1, 64'd1, 64'd31, ALU_SLLW, 64'hFFFFFFFF80000000);
        issue(1'b1, 64'd1, 64'hFFFFFFFFFFFFFFFF, ALU_SLTU, 64'd1);
        issue(1'b1, 64'd1, 64'hFFFFFFFFFFFFFFFF, ALU_SLT, 64'd0);
        issue(1'b1, 64'd1, 64'h43, ALU_SLL, 64'd8);
        issue(1'b1, 64'h8000000000000000, 64'd63, ALU_SRA, 64'hFFFFFFFFFFFFFFFF);
        issue(1'b1, 64'h8000000000000000, 64'h7F, ALU_SRL, 64'd1);
        issue(1'b1, 64'd5, 64'd7, ALU_SUB, 64'hFFFFFFFFFFFFFFFE);
        issue(1'b1, 64'hF0, 64'h0F, ALU_OR, 64'hFF);
        issue(1'b1, 64'hFF00, 64'h0FF0, ALU_AND, 64'h0F00);
        issue(1'b1, 64'd0, 64'd1234, ALU_PASSB, 64'd1234);
        issue(1'b1, 64'd1, 64'd2, 5'd31, 64'd0);
        issue(1'b1, 64'd3, 64'd4, 5'd16, 64'd0);

        // Alternation: last transfer was port 1, so port 0 leads.
        cnt0 = 0; cnt1 = 0; n0 = 0; n1 = 0;
        drive(1'b0, 64'd0, 64'd11, ALU_ADD);
        drive(1'b1, 64'd100, 64'd0, ALU_SUB);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("alt_ready0", {63'd0, req0_ready}, {63'd0, (i % 2) == 0});
            check("alt_ready1", {63'd0, req1_ready}, {63'd0, (i % 2) == 1});
            if (req0_ready === 1'b1) cnt0++;
            if (req1_ready === 1'b1) cnt1++;
            if ((i % 2) == 0) begin
                exp_q.push_back('{id: 1'b0, c: 64'(n0 * 3 + 11)});
                n0++;
            end else begin
                exp_q.push_back('{id: 1'b1, c: 64'(100 - n1)});
                n1++;
            end
            tick();
            req0_a = 64'(n0 * 3);
            req1_b = 64'(n1);
        end
        check("alt_cnt0", 64'(cnt0), 64'd5);
        check("alt_cnt1", 64'(cnt1), 64'd5);

        // Backpressure: buffer holds port 1's 100-4 result.
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready0", {63'd0, req0_ready}, 64'd0);
            check("bp_ready1", {63'd0, req1_ready}, 64'd0);
            check("bp_valid", {63'd0, resp_valid}, 64'd1);
            check("bp_resp_c", resp_c, 64'd96);
            check("bp_resp_id", {63'd0, resp_id}, 64'd1);
            tick();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_ready0", {63'd0, req0_ready}, 64'd1);
        check("bp_rel_ready1", {63'd0, req1_ready}, 64'd0);
        exp_q.push_back('{id: 1'b0, c: 64'd26});
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("no_bubble", {63'd0, resp_valid}, 64'd1);
        tick();

        for (int i = 0; i < 4; i++)
            issue(1'b1, 64'd0, 64'(200 + i), ALU_PASSB, 64'(200 + i));
        drive(1'b0, 64'hF0F0, 64'hFF, ALU_XOR);
        drive(1'b1, 64'd9, 64'd9, ALU_ADD);
        @(negedge clk);
        check("after_solo_ready0", {63'd0, req0_ready}, 64'd1);
        check("after_solo_ready1", {63'd0, req1_ready}, 64'd0);
        exp_q.push_back('{id: 1'b0, c: 64'hF00F});
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        tick();

        // Reset while FULL: the held port 0 result must vanish and prio return to 0.
        resp_ready = 1'b0;
        issue(1'b0, 64'd50, 64'd8, ALU_SUB, 64'd42);
        @(negedge clk);
        check("full_before_rst", {63'd0, resp_valid}, 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_valid", {63'd0, resp_valid}, 64'd0);
        check("async_rst_c", resp_c, 64'd0);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("rst_prio_ready0", {63'd0, req0_ready}, 64'd1);
        check("rst_prio_ready1", {63'd0, req1_ready}, 64'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("post_rst_idle", {63'd0, resp_valid}, 64'd0);
        end
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
